// File: rtl/periph_bus_decoder_if.sv
// Purpose: core data-memory port and peripheral slave buses bundled for the decoder.
// Latency: none (signal bundle only).
// Backpressure: none; slaves accept every write and return reads one cycle later.
interface periph_bus_decoder_if #(
   parameter int NSLV = 4
);
   // master (core) side
   logic                 m_wr_en_i;
   logic [31:0]          m_wr_addr_i;
   logic [31:0]          m_wr_data_i;
   logic                 m_rd_en_i;
   logic [31:0]          m_rd_addr_i;
   logic [31:0]          m_rd_data_o;
   logic                 m_rd_valid_o;
   // peripheral side
   logic [NSLV-1:0]      s_wr_en_o;
   logic [31:0]          s_wr_addr_o;
   logic [31:0]          s_wr_data_o;
   logic [31:0]          s_rd_addr_o;
   logic [NSLV*32-1:0]   s_rd_data_i;

   // Environment view: drives requests and slave read data, observes decoder outputs.
   modport master (
      output m_wr_en_i, m_wr_addr_i, m_wr_data_i, m_rd_en_i, m_rd_addr_i, s_rd_data_i,
      input  m_rd_data_o, m_rd_valid_o, s_wr_en_o, s_wr_addr_o, s_wr_data_o, s_rd_addr_o
   );

   // Decoder view: it is the slave of the core port.
   modport slave (
      input  m_wr_en_i, m_wr_addr_i, m_wr_data_i, m_rd_en_i, m_rd_addr_i, s_rd_data_i,
      output m_rd_data_o, m_rd_valid_o, s_wr_en_o, s_wr_addr_o, s_wr_data_o, s_rd_addr_o
   );
endinterface

// File: rtl/periph_bus_decoder.sv
// Purpose: address decode / read-return mux from core data port to NSLV peripherals, with unmapped-access debug capture.
// Latency: writes combinational; read data + valid one cycle after the request (matches slave read latency).
// Backpressure: none; one read and one write accepted every cycle, back-to-back reads without bubbles.
module periph_bus_decoder #(
   parameter int          NSLV       = 4,
   parameter int          SEL_MSB    = 31,
   parameter int          SEL_LSB    = 28,
   parameter logic [31:0] DEFAULT_RD = 32'h0,
   parameter int          CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   periph_bus_decoder_if.slave   bus,
   input  logic                  err_clr_i,
   output logic                  err_o,
   output logic [31:0]           err_addr_o,
   output logic [CNT_W-1:0]      err_cnt_o
);

   localparam int              IDXW     = SEL_MSB - SEL_LSB + 1;
   localparam logic [IDXW:0]   NSLV_W   = (IDXW+1)'(NSLV);
   localparam logic [31:0]     SEL_MASK = ((32'h1 << IDXW) - 32'h1) << SEL_LSB;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // ---------------------------------------------------------------
   // Decode of both address channels
   // ---------------------------------------------------------------
   logic [IDXW-1:0] w_wr_idx;
   logic [IDXW-1:0] w_rd_idx;
   logic            w_wr_map;
   logic            w_rd_map;

   assign w_wr_idx = bus.m_wr_addr_i[SEL_MSB:SEL_LSB];
   assign w_rd_idx = bus.m_rd_addr_i[SEL_MSB:SEL_LSB];
   assign w_wr_map = ({1'b0, w_wr_idx} < NSLV_W);
   assign w_rd_map = ({1'b0, w_rd_idx} < NSLV_W);

   // ---------------------------------------------------------------
   // Write path: purely combinational fan-out to the selected slave
   // ---------------------------------------------------------------
   logic [NSLV-1:0] w_wr_en;

   // One-hot write enable; an unmapped write enables nobody.
   always_comb begin
      w_wr_en = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (bus.m_wr_en_i && w_wr_map && (w_wr_idx == IDXW'(k))) begin
            w_wr_en[k] = 1'b1;
         end
      end
   end

   // Slaves see an address local to their window, so the select field is stripped.
   assign bus.s_wr_en_o   = w_wr_en;
   assign bus.s_wr_addr_o = bus.m_wr_addr_i & ~SEL_MASK;
   assign bus.s_wr_data_o = bus.m_wr_data_i;
   assign bus.s_rd_addr_o = bus.m_rd_addr_i & ~SEL_MASK;

   // ---------------------------------------------------------------
   // Read path: remember which slave was asked, mux its data next cycle
   // ---------------------------------------------------------------
   logic [IDXW-1:0] r_sel_q;
   logic            r_rvld_q;
   logic            r_rmap_q;

   // Track the outstanding read so the return can be steered one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_q  <= '0;
         r_rvld_q <= 1'b0;
         r_rmap_q <= 1'b0;
      end else begin
         r_sel_q  <= w_rd_idx;
         r_rmap_q <= w_rd_map;
         r_rvld_q <= bus.m_rd_en_i;
      end
   end

   logic [31:0] w_rd_mux;

   // Return mux: unmapped reads and idle cycles both yield DEFAULT_RD.
   always_comb begin
      w_rd_mux = DEFAULT_RD;
      if (r_rvld_q && r_rmap_q) begin
         for (int k = 0; k < NSLV; k++) begin
            if (r_sel_q == IDXW'(k)) begin
               w_rd_mux = bus.s_rd_data_i[k*32 +: 32];
            end
         end
      end
   end

   assign bus.m_rd_data_o  = w_rd_mux;
   assign bus.m_rd_valid_o = r_rvld_q;

   // ---------------------------------------------------------------
   // Unmapped-access debug capture
   // ---------------------------------------------------------------
   logic             r_err_q;
   logic [31:0]      r_err_addr_q;
   logic [CNT_W-1:0] r_err_cnt_q;

   logic             w_we;
   logic             w_re;
   logic [1:0]       w_n;
   logic             w_base_err;
   logic [31:0]      w_base_addr;
   logic [CNT_W-1:0] w_base_cnt;
   logic [CNT_W:0]   w_cnt_sum;
   logic             w_err_nxt;
   logic [31:0]      w_addr_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;

   assign w_we = bus.m_wr_en_i & ~w_wr_map;
   assign w_re = bus.m_rd_en_i & ~w_rd_map;
   assign w_n  = {1'b0, w_we} + {1'b0, w_re};

   // Clear selects an all-zero base; this cycle's events still land on top of it,
   // so an error coincident with a clear is never lost.
   always_comb begin
      w_base_err  = err_clr_i ? 1'b0 : r_err_q;
      w_base_addr = err_clr_i ? 32'h0 : r_err_addr_q;
      w_base_cnt  = err_clr_i ? '0 : r_err_cnt_q;

      w_err_nxt   = w_base_err | (w_n != 2'd0);

      // Only the first unmapped access since clear is recorded; write wins a tie.
      w_addr_nxt  = w_base_addr;
      if (!w_base_err) begin
         if (w_we) begin
            w_addr_nxt = bus.m_wr_addr_i;
         end else if (w_re) begin
            w_addr_nxt = bus.m_rd_addr_i;
         end
      end

      // Saturating add: one extra bit catches overflow past all-ones.
      w_cnt_sum = {1'b0, w_base_cnt} + (CNT_W+1)'(w_n);
      if (w_cnt_sum > {1'b0, CNT_MAX}) begin
         w_cnt_nxt = CNT_MAX;
      end else begin
         w_cnt_nxt = w_cnt_sum[CNT_W-1:0];
      end
   end

   // Error state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_q      <= 1'b0;
         r_err_addr_q <= 32'h0;
         r_err_cnt_q  <= '0;
      end else begin
         r_err_q      <= w_err_nxt;
         r_err_addr_q <= w_addr_nxt;
         r_err_cnt_q  <= w_cnt_nxt;
      end
   end

   assign err_o      = r_err_q;
   assign err_addr_o = r_err_addr_q;
   assign err_cnt_o  = r_err_cnt_q;

endmodule

// File: tb/tb_periph_bus_decoder.sv
// Purpose: randomized + directed scoreboard bench for periph_bus_decoder.
// Latency: expected read returns are queued at the request edge and popped one cycle later.
// Backpressure: none; the bench issues a request every cycle.
module tb_periph_bus_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        err_clr_i = 1'b0;
   logic        err_o;
   logic [31:0] err_addr_o;
   logic [7:0]  err_cnt_o;

   always #5 clk = ~clk;

   periph_bus_decoder_if #(.NSLV(4)) bus ();

   periph_bus_decoder #(
      .NSLV(4), .SEL_MSB(31), .SEL_LSB(28), .DEFAULT_RD(32'h0), .CNT_W(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .err_clr_i  (err_clr_i),
      .err_o      (err_o),
      .err_addr_o (err_addr_o),
      .err_cnt_o  (err_cnt_o)
   );

   int vectors    = 0;
   int miscompares = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endfunction

   // Slave models: each slave registers its read address and returns a fixed table word.
   logic [31:0] mem [0:3][0:15];
   logic [31:0] sl_addr = 32'h0;

   always @(posedge clk) sl_addr <= bus.s_rd_addr_o;

   always_comb begin
      bus.s_rd_data_i = '0;
      for (int k = 0; k < 4; k++) bus.s_rd_data_i[k*32 +: 32] = mem[k][sl_addr[5:2]];
   end

   // Reference model state.
   typedef struct { bit vld; logic [31:0] data; } rd_exp_t;
   rd_exp_t     rdq[$];
   bit          m_err  = 1'b0;
   logic [31:0] m_eaddr = 32'h0;
   int          m_cnt  = 0;

   function automatic bit mapped(logic [31:0] a);
      int sel;
      sel = int'(a >> 28);
      return sel < 4;
   endfunction

   // Drive one cycle of stimulus, check the combinational slave-side outputs,
   // then advance the model at the same clock edge the DUT samples.
   task automatic cycle(input bit we, input logic [31:0] wa, input logic [31:0] wd,
                        input bit re, input logic [31:0] ra, input bit clr);
      logic [3:0]  exp_en;
      int          n;
      bit          ue, ur;
      rd_exp_t     e;
      bus.m_wr_en_i   = we;
      bus.m_wr_addr_i = wa;
      bus.m_wr_data_i = wd;
      bus.m_rd_en_i   = re;
      bus.m_rd_addr_i = ra;
      err_clr_i       = clr;
      @(negedge clk);
      exp_en = (we && mapped(wa)) ? (4'b0001 << (wa >> 28)) : 4'b0000;
      chk("s_wr_en_o",   {28'h0, bus.s_wr_en_o}, {28'h0, exp_en});
      chk("s_wr_addr_o", bus.s_wr_addr_o, wa % 32'h1000_0000);
      chk("s_wr_data_o", bus.s_wr_data_o, wd);
      chk("s_rd_addr_o", bus.s_rd_addr_o, ra % 32'h1000_0000);
      @(posedge clk);
      if (rst_n) begin
         e.vld  = re;
         e.data = (re && mapped(ra)) ? mem[ra >> 28][(ra >> 2) % 16] : 32'h0;
         rdq.push_back(e);
         ue = we && !mapped(wa);
         ur = re && !mapped(ra);
         n  = int'(ue) + int'(ur);
         if (clr) begin
            m_err = 1'b0; m_eaddr = 32'h0; m_cnt = 0;
         end
         if (n > 0) begin
            if (!m_err) m_eaddr = ue ? wa : ra;
            m_err = 1'b1;
         end
         m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
      end
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   // Monitor: every cycle compares the read return and error state against the model.
   initial begin
      rd_exp_t e;
      forever begin
         @(negedge clk);
         if (rdq.size() > 0) e = rdq.pop_front();
         else begin e.vld = 1'b0; e.data = 32'h0; end
         chk("m_rd_valid_o", {31'h0, bus.m_rd_valid_o}, {31'h0, e.vld});
         chk("m_rd_data_o",  bus.m_rd_data_o, e.data);
         chk("err_o",        {31'h0, err_o}, {31'h0, m_err});
         chk("err_addr_o",   err_addr_o, m_eaddr);
         chk("err_cnt_o",    {24'h0, err_cnt_o}, m_cnt[31:0]);
      end
   end

   initial begin
      logic [31:0] r1, r2, wa, ra;
      for (int k = 0; k < 4; k++)
         for (int w = 0; w < 16; w++) mem[k][w] = $urandom;
      mem[0][1] = 32'h0000_00A5;

      bus.m_wr_en_i = 1'b0; bus.m_wr_addr_i = 32'h0; bus.m_wr_data_i = 32'h0;
      bus.m_rd_en_i = 1'b0; bus.m_rd_addr_i = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Mapped write to slave 1: local address, no error.
      cycle(1'b1, 32'h1000_0004, 32'h5, 1'b0, 32'h0, 1'b0);
      chk("wr_no_err", {31'h0, err_o}, 32'h0);
      // Read slave 0 word 1 -> 0xA5 next cycle.
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0004, 1'b0);
      chk("rd_a5_data", bus.m_rd_data_o, 32'h0000_00A5);
      // Back-to-back reads to every slave.
      for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, (k << 28) | 32'h8, 1'b0);
      idle();
      // Unmapped write then unmapped read.
      cycle(1'b1, 32'h7000_0000, 32'h1, 1'b0, 32'h0, 1'b0);
      chk("uw_addr", err_addr_o, 32'h7000_0000);
      chk("uw_cnt",  {24'h0, err_cnt_o}, 32'd1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h5000_0000, 1'b0);
      chk("ur_cnt",  {24'h0, err_cnt_o}, 32'd2);
      chk("ur_data", bus.m_rd_data_o, 32'h0);
      // Clear coincident with unmapped write + read.
      cycle(1'b1, 32'h9000_0010, 32'h2, 1'b1, 32'hF000_0020, 1'b1);
      chk("clr_cnt",  {24'h0, err_cnt_o}, 32'd2);
      chk("clr_addr", err_addr_o, 32'h9000_0010);
      // 300 unmapped accesses saturate the counter.
      for (int i = 0; i < 149; i++) cycle(1'b1, 32'h8000_0000, 32'h0, 1'b1, 32'hC000_0000, 1'b0);
      chk("sat_cnt", {24'h0, err_cnt_o}, 32'hFF);
      cycle(1'b1, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("sat_hold", {24'h0, err_cnt_o}, 32'hFF);

      // Randomized traffic with occasional clears.
      for (int i = 0; i < 1500; i++) begin
         r1 = $urandom; r2 = $urandom;
         wa = ({28'h0, 4'($urandom_range(0, 7))} << 28) | (r1 % 32'h1000_0000);
         ra = ({28'h0, 4'($urandom_range(0, 7))} << 28) | (r2 % 32'h1000_0000);
         cycle(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ra,
               ($urandom_range(0, 31) == 0));
      end

      // Reset between a read request and its return (with error state set).
      cycle(1'b1, 32'hA000_0000, 32'h0, 1'b1, 32'h2000_0004, 1'b0);
      #2 rst_n = 1'b0;
      rdq.delete();
      m_err = 1'b0; m_eaddr = 32'h0; m_cnt = 0;
      @(negedge clk);
      chk("rst_vld", {31'h0, bus.m_rd_valid_o}, 32'h0);
      chk("rst_cnt", {24'h0, err_cnt_o}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) idle();

      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
